// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared constants for the fetch-control slice.
//   TAM_DFLT          default program address width
//   ST_RUN..ST_HALT   CoreStatus fetch-mode codes (also the FSM state encoding)
//   advances_pc()     whether a fetch mode lets the PC step on an idle cycle
package nrisc_pkg;

  localparam int TAM_DFLT = 16;

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_STALL = 2'b01;
  localparam logic [1:0] ST_REDIR = 2'b10;
  localparam logic [1:0] ST_HALT  = 2'b11;

  // After a redirect the memory fetches progADDR itself, so the PC must hold
  // for one idle cycle; in RUN/STALL it steps to the next address.
  function automatic logic advances_pc(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_STALL);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack: small LIFO of return addresses.
//   clk, rst        clock, asynchronous active-low reset (empties the stack)
//   push, push_data write push_data at entry[count]; ignored when full
//   pop             drop entry[count-1]; ignored when empty; wins over push
//   top             entry[count-1] (don't-care when empty)
//   full, empty     count == RAS_DEPTH / count == 0
//   count           number of valid entries, 0..RAS_DEPTH
module ras_stack #(
  parameter int TAM       = 16,
  parameter int RAS_DEPTH = 4,
  localparam int CW       = $clog2(RAS_DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [TAM-1:0] push_data,
  output logic [TAM-1:0] top,
  output logic           full,
  output logic           empty,
  output logic [CW-1:0]  count
);

  logic [TAM-1:0] entry_r [RAS_DEPTH];
  logic [CW-1:0]  count_r;
  logic [CW-1:0]  count_m1_s;
  logic [CW-2:0]  wr_idx_s;
  logic [CW-2:0]  rd_idx_s;

  assign count_m1_s = count_r - CW'(1);
  // count < RAS_DEPTH whenever a push is accepted, so the low bits index safely
  assign wr_idx_s   = count_r[CW-2:0];
  assign rd_idx_s   = count_m1_s[CW-2:0];
  assign full       = (count_r == CW'(RAS_DEPTH));
  assign empty      = (count_r == CW'(0));
  assign top        = entry_r[rd_idx_s];
  assign count      = count_r;

  // Stack storage and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= CW'(0);
      for (int i = 0; i < RAS_DEPTH; i++) begin
        entry_r[i] <= TAM'(0);
      end
    end else if (pop && !empty) begin
      count_r <= count_m1_s;
    end else if (push && !full) begin
      entry_r[wr_idx_s] <= push_data;
      count_r           <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// prog_counter: fetch-control stage feeding the program memory.
//   clk, rst       clock, asynchronous active-low reset
//   stall          hold the PC
//   jump, target   load target into the PC
//   call           load target and push PC+1 onto the return stack
//   ret            pop the return stack into the PC
//   halt, resume   freeze / unfreeze fetch
//   progADDR       registered program address (address being fetched)
//   CoreStatus     registered fetch mode, doubles as the FSM state
//   ras_ovf        sticky: call issued while the return stack was full
//   ras_unf        sticky: ret issued while the return stack was empty
module prog_counter import nrisc_pkg::*; #(
  parameter int             TAM       = TAM_DFLT,
  parameter int             RAS_DEPTH = 4,
  parameter logic [TAM-1:0] RST_ADDR  = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           jump,
  input  logic           call,
  input  logic           ret,
  input  logic [TAM-1:0] target,
  input  logic           halt,
  input  logic           resume,
  output logic [TAM-1:0] progADDR,
  output logic [1:0]     CoreStatus,
  output logic           ras_ovf,
  output logic           ras_unf
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [TAM-1:0] pc_inc_s;
  logic [TAM-1:0] next_pc_s;
  logic [1:0]     next_st_s;
  logic           push_s;
  logic           pop_s;
  logic           set_ovf_s;
  logic           set_unf_s;
  logic [TAM-1:0] ras_top_s;
  logic           ras_full_s;
  logic           ras_empty_s;
  logic [CW-1:0]  ras_count_s;

  // Wraps modulo 2^TAM through truncation.
  assign pc_inc_s = progADDR + TAM'(1);

  ras_stack #(
    .TAM       (TAM),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_inc_s),
    .top       (ras_top_s),
    .full      (ras_full_s),
    .empty     (ras_empty_s),
    .count     (ras_count_s)
  );

  // Next-state decode; one request per cycle, lower priorities are discarded.
  always_comb begin
    next_pc_s = progADDR;
    next_st_s = CoreStatus;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    set_ovf_s = 1'b0;
    set_unf_s = 1'b0;
    case (CoreStatus)
      ST_HALT: begin
        if (resume) begin
          next_st_s = ST_REDIR;
        end else begin
          next_st_s = ST_HALT;
        end
      end
      default: begin
        if (halt) begin
          next_st_s = ST_HALT;
        end else if (ret) begin
          if (!ras_empty_s) begin
            pop_s     = 1'b1;
            next_pc_s = ras_top_s;
            next_st_s = ST_REDIR;
          end else begin
            set_unf_s = 1'b1;
            next_st_s = ST_RUN;
          end
        end else if (call) begin
          // A full stack drops the push but the redirect still happens.
          push_s    = !ras_full_s;
          set_ovf_s = ras_full_s;
          next_pc_s = target;
          next_st_s = ST_REDIR;
        end else if (jump) begin
          next_pc_s = target;
          next_st_s = ST_REDIR;
        end else if (stall) begin
          next_st_s = ST_STALL;
        end else begin
          next_st_s = ST_RUN;
          if (advances_pc(CoreStatus)) begin
            next_pc_s = pc_inc_s;
          end else begin
            next_pc_s = progADDR;
          end
        end
      end
    endcase
  end

  // Registered PC, fetch mode and sticky stack-error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      progADDR   <= RST_ADDR;
      CoreStatus <= ST_REDIR;
      ras_ovf    <= 1'b0;
      ras_unf    <= 1'b0;
    end else begin
      progADDR   <= next_pc_s;
      CoreStatus <= next_st_s;
      ras_ovf    <= ras_ovf | set_ovf_s;
      ras_unf    <= ras_unf | set_unf_s;
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
module tb_prog_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic        halt = 1'b0, resume = 1'b0;
  logic [15:0] target = 16'h0000;
  logic [15:0] progADDR;
  logic [1:0]  CoreStatus;
  logic        ras_ovf, ras_unf;

  prog_counter #(.TAM(16), .RAS_DEPTH(4), .RST_ADDR(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump(jump), .call(call), .ret(ret),
    .target(target), .halt(halt), .resume(resume), .progADDR(progADDR),
    .CoreStatus(CoreStatus), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [1:0]  st;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: fetch mode as a name-level code, stack as a plain queue.
  int   m_pc;
  int   m_mode;          // 0 RUN, 1 STALL, 2 REDIRECT, 3 HALT
  int   m_stack[$];
  bit   m_ovf, m_unf;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.pc  = m_pc[15:0];
    e.st  = m_mode[1:0];
    e.ovf = m_ovf;
    e.unf = m_unf;
    return e;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_mode = 2; m_stack.delete(); m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step();
    if (m_mode == 3) begin
      if (resume) m_mode = 2;
    end else if (halt) begin
      m_mode = 3;
    end else if (ret) begin
      if (m_stack.size() > 0) begin
        m_pc = m_stack.pop_back();
        m_mode = 2;
      end else begin
        m_unf = 1;
        m_mode = 0;
      end
    end else if (call) begin
      if (m_stack.size() < 4) m_stack.push_back((m_pc + 1) % 65536);
      else m_ovf = 1;
      m_pc = target;
      m_mode = 2;
    end else if (jump) begin
      m_pc = target;
      m_mode = 2;
    end else if (stall) begin
      m_mode = 1;
    end else begin
      // memory fetches the redirected address itself, so no step after a redirect
      if (m_mode != 2) m_pc = (m_pc + 1) % 65536;
      m_mode = 0;
    end
  endtask

  // Apply inputs for the coming posedge and queue the expected result.
  task automatic drive(input bit h, input bit rs, input bit st, input bit j,
                       input bit c, input bit r, input logic [15:0] t);
    halt = h; resume = rs; stall = st; jump = j; call = c; ret = r; target = t;
    model_step();
    exp_q.push_back(snapshot());
  endtask

  task automatic cyc(input bit h, input bit rs, input bit st, input bit j,
                     input bit c, input bit r, input logic [15:0] t);
    @(negedge clk);
    drive(h, rs, st, j, c, r, t);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 16'h0000);
  endtask

  // Async reset asserted away from the clock edge, checked immediately.
  task automatic do_reset();
    @(negedge clk);
    halt = 0; resume = 0; stall = 0; jump = 0; call = 0; ret = 0;
    rst = 1'b0;
    #1;
    chk("rst_pc", progADDR, 16'h0000);
    chk("rst_st", CoreStatus, 2'b10);
    chk("rst_ovf", ras_ovf, 0);
    chk("rst_unf", ras_unf, 0);
    model_reset();
    exp_q.push_back(snapshot());
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 16'h0000);
  endtask

  // Directed check of the outputs right after the posedge just driven.
  task automatic expect_now(input string name, input int pc, input int st,
                            input int ovf, input int unf);
    @(posedge clk);
    #2;
    chk({name, "_pc"}, progADDR, pc);
    chk({name, "_st"}, CoreStatus, st);
    chk({name, "_ovf"}, ras_ovf, ovf);
    chk({name, "_unf"}, ras_unf, unf);
  endtask

  // Monitor: compare every registered output update against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", progADDR, e.pc);
        chk("sb_st", CoreStatus, e.st);
        chk("sb_ovf", ras_ovf, e.ovf);
        chk("sb_unf", ras_unf, e.unf);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();
    // sequential advance after reset: 0,1,2,3
    idle(); idle(); idle();
    expect_now("seq", 16'h0003, 2'b00, 0, 0);
    // stall at PC=5
    idle(); idle();
    cyc(0, 0, 1, 0, 0, 0, 16'h0000);
    cyc(0, 0, 1, 0, 0, 0, 16'h0000);
    expect_now("stall", 16'h0005, 2'b01, 0, 0);
    idle();
    expect_now("unstall", 16'h0006, 2'b00, 0, 0);
    // call/ret
    cyc(0, 0, 0, 1, 0, 0, 16'h0010);
    cyc(0, 0, 0, 0, 1, 0, 16'h0040);
    expect_now("call", 16'h0040, 2'b10, 0, 0);
    idle(); idle();
    cyc(0, 0, 0, 0, 0, 1, 16'h0000);
    expect_now("ret", 16'h0011, 2'b10, 0, 0);
    // overflow with 5 calls, then LIFO unwind and underflow
    cyc(0, 0, 0, 0, 1, 0, 16'h0100);
    cyc(0, 0, 0, 0, 1, 0, 16'h0200);
    cyc(0, 0, 0, 0, 1, 0, 16'h0300);
    cyc(0, 0, 0, 0, 1, 0, 16'h0400);
    cyc(0, 0, 0, 0, 1, 0, 16'h0500);
    expect_now("ovf", 16'h0500, 2'b10, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 16'h0000);
    expect_now("pop1", 16'h0301, 2'b10, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 16'h0000);
    expect_now("pop2", 16'h0201, 2'b10, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 16'h0000);
    expect_now("pop3", 16'h0101, 2'b10, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 16'h0000);
    expect_now("pop4", 16'h0012, 2'b10, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 16'h0000);
    expect_now("unf", 16'h0012, 2'b00, 1, 1);
    idle();
    expect_now("unf_adv", 16'h0013, 2'b00, 1, 1);
    // halt ignores everything but resume
    cyc(0, 0, 0, 1, 0, 0, 16'h0008);
    idle();
    cyc(1, 0, 0, 0, 0, 0, 16'h0000);
    cyc(0, 0, 0, 1, 0, 0, 16'h1234);
    cyc(0, 0, 0, 0, 1, 0, 16'h4321);
    cyc(0, 0, 1, 0, 0, 1, 16'h0000);
    expect_now("halt", 16'h0008, 2'b11, 1, 1);
    cyc(0, 1, 0, 0, 0, 0, 16'h0000);
    expect_now("resume", 16'h0008, 2'b10, 1, 1);
    // wrap-around
    cyc(0, 0, 0, 1, 0, 0, 16'hFFFF);
    idle();
    expect_now("wrap_hold", 16'hFFFF, 2'b00, 1, 1);
    idle();
    expect_now("wrap", 16'h0000, 2'b00, 1, 1);
    // call+ret collision on empty stack after a fresh reset
    do_reset();
    cyc(0, 0, 0, 0, 1, 1, 16'h0077);
    expect_now("collide", 16'h0000, 2'b00, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 16'h0000);
    expect_now("no_push", 16'h0000, 2'b00, 0, 1);
    // randomized traffic with occasional async resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            16'($urandom));
      end
    end
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
